fetch_unit: RTL and testbench

Instruction fetch stage of Core101, directly upstream of decode and the immediate generator. Keeps the program counter and issues sequential word fetches to instruction memory over a valid/ready request channel. Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake. Handles PC redirects from branch/jump resolution by flushing the buffer and discarding responses that are still in flight.

---
 rtl/core101_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/core101_pkg.sv
// Core101 shared definitions: datapath width, NOP encoding, reset PC and fetch FSM states.
package core101_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch stage: synchronous FIFO of {pc, instr} entries.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush dominates both push and pop in the same cycle.
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Core101 fetch stage: sequential word fetch with credit-limited requests,
// buffered delivery to decode, and redirect with stale-response draining.
module fetch_unit
  import core101_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clock_in,
  input  logic            reset_in,
  output logic            imem_req_valid_out,
  output logic [XLEN-1:0] imem_req_addr_out,
  input  logic            imem_req_ready_in,
  input  logic            imem_resp_valid_in,
  input  logic [XLEN-1:0] imem_resp_data_in,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic            ins_valid_out,
  output logic [XLEN-1:0] ins_output,
  output logic [XLEN-1:0] ins_pc_out,
  input  logic            ins_ready_in
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, resp_pc_q, last_pc_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_count, fifo_count_d;
  logic [CW:0]     credit_sum;
  logic            req_valid_q, req_valid_d;
  logic            accept, push, pop;
  logic            fifo_full, fifo_empty;
  logic [63:0]     fifo_head;
  logic [XLEN-1:0] redirect_pc;

  assign redirect_pc = redirect_pc_in & ~32'h3;
  assign accept      = req_valid_q && imem_req_ready_in;
  assign push        = (state_q == FETCH) && imem_resp_valid_in && !redirect_valid_in;
  assign pop         = ins_valid_out && ins_ready_in;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock_in),
    .rst_n (reset_in),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid_in),
    .wdata ({resp_pc_q, imem_resp_data_in}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credits use next-cycle occupancy so the registered request valid never overcommits.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept)             outstanding_d = outstanding_d + CW'(1);
    if (imem_resp_valid_in) outstanding_d = outstanding_d - CW'(1);
    fifo_count_d = fifo_count;
    if (redirect_valid_in) begin
      fifo_count_d = '0;
    end else begin
      if (push) fifo_count_d = fifo_count_d + CW'(1);
      if (pop)  fifo_count_d = fifo_count_d - CW'(1);
    end
    credit_sum = {1'b0, outstanding_d} + {1'b0, fifo_count_d};
  end

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: state_d = FETCH;
      DRAIN: begin
        if (imem_resp_valid_in) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_q == CW'(1)) state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    if (redirect_valid_in) begin
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d == '0) ? FETCH : DRAIN;
    end
    req_valid_d = (state_d == FETCH) && (credit_sum < (CW + 1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      req_valid_q   <= 1'b0;
      last_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      req_valid_q   <= req_valid_d;
      if (redirect_valid_in) begin
        pc_q      <= redirect_pc;
        resp_pc_q <= redirect_pc;
      end else begin
        if (accept) pc_q      <= pc_q + 32'd4;
        if (push)   resp_pc_q <= resp_pc_q + 32'd4;
      end
      if (!fifo_empty) last_pc_q <= fifo_head[63:32];
    end
  end

  assign imem_req_valid_out = req_valid_q;
  assign imem_req_addr_out  = pc_q;
  assign ins_valid_out      = !fifo_empty;
  assign ins_output         = fifo_empty ? NOP_INSTR : fifo_head[31:0];
  assign ins_pc_out         = fifo_empty ? last_pc_q : fifo_head[63:32];

  a_no_push_when_full: assert property (@(posedge clock_in) disable iff (!reset_in)
    !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with controllable response enable.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        imem_req_valid_out;
  logic [31:0] imem_req_addr_out;
  logic        imem_req_ready_in;
  logic        imem_resp_valid_in;
  logic [31:0] imem_resp_data_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        ins_valid_out;
  logic [31:0] ins_output;
  logic [31:0] ins_pc_out;
  logic        ins_ready_in;

  logic [31:0] mem_q[$];
  bit          mem_en;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clock_in           (clk),
    .reset_in           (reset_in),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_addr_out  (imem_req_addr_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_resp_valid_in (imem_resp_valid_in),
    .imem_resp_data_in  (imem_resp_data_in),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_pc_in     (redirect_pc_in),
    .ins_valid_out      (ins_valid_out),
    .ins_output         (ins_output),
    .ins_pc_out         (ins_pc_out),
    .ins_ready_in       (ins_ready_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, ".req_valid"}, 32'(imem_req_valid_out), 32'(v));
    chk({tag, ".req_addr"}, imem_req_addr_out, a);
  endtask

  task automatic exp_ins(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".ins_valid"}, 32'(ins_valid_out), 32'(v));
    chk({tag, ".ins_pc"}, ins_pc_out, pc);
    chk({tag, ".ins"}, ins_output, ins);
  endtask

  // One clock: memory accepts requests, answers in order one cycle or more later.
  task automatic tick();
    logic        acc;
    logic        fired;
    logic [31:0] a;
    acc   = imem_req_valid_out && imem_req_ready_in;
    a     = imem_req_addr_out;
    fired = imem_resp_valid_in;
    @(posedge clk);
    if (fired) void'(mem_q.pop_front());
    if (acc) mem_q.push_back(a);
    #1;
    if (mem_en && mem_q.size() > 0) begin
      imem_resp_valid_in = 1'b1;
      imem_resp_data_in  = mem_q[0] ^ 32'hE000_0000;
    end else begin
      imem_resp_valid_in = 1'b0;
      imem_resp_data_in  = '0;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid_in = 1'b1;
    redirect_pc_in    = pc;
    tick();
    redirect_valid_in = 1'b0;
    redirect_pc_in    = '0;
  endtask

  initial begin
    reset_in           = 1'b0;
    imem_req_ready_in  = 1'b1;
    imem_resp_valid_in = 1'b0;
    imem_resp_data_in  = '0;
    redirect_valid_in  = 1'b0;
    redirect_pc_in     = '0;
    ins_ready_in       = 1'b1;
    mem_en             = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_req("rst", 1'b0, 32'h0);
    exp_ins("rst", 1'b0, 32'h0, NOP);
    reset_in = 1'b1;

    // Sequential fetch, memory latency 1, decode always ready
    exp_req("c0", 1'b0, 32'h0);
    tick(); exp_req("c1", 1'b1, 32'h0);  exp_ins("c1", 1'b0, 32'h0, NOP);
    tick(); exp_req("c2", 1'b1, 32'h4);  exp_ins("c2", 1'b0, 32'h0, NOP);
    tick(); exp_req("c3", 1'b0, 32'h8);  exp_ins("c3", 1'b1, 32'h0, 32'hE000_0000);
    tick(); exp_req("c4", 1'b1, 32'h8);  exp_ins("c4", 1'b1, 32'h4, 32'hE000_0004);
    tick(); exp_req("c5", 1'b1, 32'hC);  exp_ins("c5", 1'b0, 32'h4, NOP);
    tick(); exp_req("c6", 1'b0, 32'h10); exp_ins("c6", 1'b1, 32'h8, 32'hE000_0008);

    // Decode stalls: buffer fills, requests stop, then resume without loss
    ins_ready_in = 1'b0;
    repeat (3) tick();
    exp_req("stall", 1'b0, 32'h10); exp_ins("stall", 1'b1, 32'h8, 32'hE000_0008);
    ins_ready_in = 1'b1;
    tick(); exp_req("c10", 1'b1, 32'h10); exp_ins("c10", 1'b1, 32'hC, 32'hE000_000C);
    tick(); exp_req("c11", 1'b1, 32'h14); exp_ins("c11", 1'b0, 32'hC, NOP);
    tick(); exp_req("c12", 1'b0, 32'h18); exp_ins("c12", 1'b1, 32'h10, 32'hE000_0010);
    tick(); exp_req("c13", 1'b1, 32'h18); exp_ins("c13", 1'b1, 32'h14, 32'hE000_0014);

    // Two requests outstanding, then redirect to 0x100
    mem_en = 1'b0;
    tick(); exp_req("c14", 1'b1, 32'h1C); exp_ins("c14", 1'b0, 32'h14, NOP);
    tick(); exp_req("c15", 1'b0, 32'h20);
    mem_en = 1'b1;
    redirect(32'h100);
    exp_req("rd1+1", 1'b0, 32'h100); exp_ins("rd1+1", 1'b0, 32'h14, NOP);
    tick(); exp_req("rd1+2", 1'b0, 32'h100); exp_ins("rd1+2", 1'b0, 32'h14, NOP);
    tick(); exp_req("rd1+3", 1'b1, 32'h100); exp_ins("rd1+3", 1'b0, 32'h14, NOP);
    tick(); exp_req("rd1+4", 1'b1, 32'h104); exp_ins("rd1+4", 1'b0, 32'h14, NOP);
    tick(); exp_req("rd1+5", 1'b0, 32'h108); exp_ins("rd1+5", 1'b1, 32'h100, 32'hE000_0100);

    // Unaligned redirect with nothing stale; coincides with a pop and a response
    redirect(32'h203);
    exp_req("rd2+1", 1'b1, 32'h200); exp_ins("rd2+1", 1'b0, 32'h100, NOP);
    tick(); exp_req("rd2+2", 1'b1, 32'h204); exp_ins("rd2+2", 1'b0, 32'h100, NOP);
    tick(); exp_req("rd2+3", 1'b0, 32'h208); exp_ins("rd2+3", 1'b1, 32'h200, 32'hE000_0200);
    tick(); exp_req("rd2+4", 1'b1, 32'h208); exp_ins("rd2+4", 1'b1, 32'h204, 32'hE000_0204);
    tick(); exp_req("rd2+5", 1'b1, 32'h20C); exp_ins("rd2+5", 1'b0, 32'h204, NOP);

    // Redirect in a cycle with both an accept (0x20C) and a response (0x208)
    redirect(32'h300);
    exp_req("rd3+1", 1'b0, 32'h300); exp_ins("rd3+1", 1'b0, 32'h204, NOP);
    tick(); exp_req("rd3+2", 1'b1, 32'h300); exp_ins("rd3+2", 1'b0, 32'h204, NOP);
    tick(); exp_req("rd3+3", 1'b1, 32'h304); exp_ins("rd3+3", 1'b0, 32'h204, NOP);
    mem_en = 1'b0;
    tick(); exp_req("rd3+4", 1'b0, 32'h308); exp_ins("rd3+4", 1'b1, 32'h300, 32'hE000_0300);

    // Enter DRAIN with the 0x304 response held back, then reset asynchronously
    redirect(32'h400);
    exp_req("rd4+1", 1'b0, 32'h400); exp_ins("rd4+1", 1'b0, 32'h300, NOP);
    tick(); exp_req("rd4+2", 1'b0, 32'h400);
    reset_in = 1'b0;
    mem_q.delete();
    imem_resp_valid_in = 1'b0;
    imem_resp_data_in  = '0;
    mem_en = 1'b1;
    #1;
    exp_req("mid_rst", 1'b0, 32'h0); exp_ins("mid_rst", 1'b0, 32'h0, NOP);
    @(posedge clk);
    #1;
    reset_in = 1'b1;
    exp_req("r2c0", 1'b0, 32'h0);
    tick(); exp_req("r2c1", 1'b1, 32'h0);
    tick(); exp_req("r2c2", 1'b1, 32'h4);
    tick(); exp_ins("r2c3", 1'b1, 32'h0, 32'hE000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
